restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider.sv | 121 ++++++++++++
 tb/tb_restoring_divider.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// restoring_divider: 8-bit unsigned sequential restoring divider.
// One iteration per clock, MSB first; Q/R update only on completion.
// Optional macro DIV_ZERO_ERR_EN adds the o_err port and a one-cycle
// divide-by-zero fast path. Without it, B=0 runs the normal iterations
// and naturally yields Q=8'hFF, R=A.
//
// state  | meaning
// S_IDLE | waiting for i_start
// S_BUSY | iterating (8 cycles, or 1 cycle on the divide-by-zero fast path)
// S_DONE | result presented, o_done high; i_start here chains a new operation

module restoring_divider (
  input  logic       i_clk,
  input  logic       i_n_rst,
  input  logic       i_start,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_q,
  output logic [7:0] o_r
`ifdef DIV_ZERO_ERR_EN
  ,
  output logic       o_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t     r_state;
  // Dividend bits shift out the top while quotient bits shift in the bottom,
  // so after eight iterations this register holds the quotient.
  logic [7:0] r_dvd;
  logic [7:0] r_b;
  // Partial remainder is always < B, so 8 stored bits suffice; the shifted
  // value below is the full 9-bit working quantity.
  logic [7:0] r_rem;
  logic [2:0] r_cnt;

  logic [8:0] w_shift;
  logic [8:0] w_diff;
  logic       w_neg;
  logic [7:0] w_rem_next;
  logic [7:0] w_q_next;

  // One trial subtraction: P + ~B + 1 on 9 bits; sign bit selects restore.
  always_comb begin
    w_shift    = {r_rem, r_dvd[7]};
    w_diff     = w_shift + ~{1'b0, r_b} + 9'd1;
    w_neg      = w_diff[8];
    w_rem_next = w_neg ? w_shift[7:0] : w_diff[7:0];
    w_q_next   = {r_dvd[6:0], ~w_neg};
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_state <= S_IDLE;
      r_dvd   <= 8'd0;
      r_b     <= 8'd0;
      r_rem   <= 8'd0;
      r_cnt   <= 3'd0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_q     <= 8'd0;
      o_r     <= 8'd0;
`ifdef DIV_ZERO_ERR_EN
      o_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_state <= S_BUSY;
            r_dvd   <= i_a;
            r_b     <= i_b;
            r_rem   <= 8'd0;
            r_cnt   <= 3'd0;
            o_busy  <= 1'b1;
`ifdef DIV_ZERO_ERR_EN
            o_err   <= 1'b0;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
`ifdef DIV_ZERO_ERR_EN
          if (r_b == 8'd0) begin
            r_state <= S_DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            o_err   <= 1'b1;
            o_q     <= 8'hFF;
            o_r     <= r_dvd;
          end else
`endif
          begin
            r_rem <= w_rem_next;
            r_dvd <= w_q_next;
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              r_state <= S_DONE;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
              o_q     <= w_q_next;
              o_r     <= w_rem_next;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider; expected values are hand-computed.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_restoring_divider;

  logic       i_clk;
  logic       i_n_rst;
  logic       i_start;
  logic [7:0] i_a;
  logic [7:0] i_b;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_q;
  logic [7:0] o_r;
`ifdef DIV_ZERO_ERR_EN
  logic       o_err;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  logic [7:0] last_q = 8'd0;
  logic [7:0] last_r = 8'd0;

  restoring_divider dut (
    .i_clk   (i_clk),
    .i_n_rst (i_n_rst),
    .i_start (i_start),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_q     (o_q),
    .o_r     (o_r)
`ifdef DIV_ZERO_ERR_EN
    ,
    .o_err   (o_err)
`endif
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Called at a falling edge: drive a request for the next rising edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    i_start = 1'b1;
    i_a     = a;
    i_b     = b;
  endtask

  // Follows one operation from its accepting edge through DONE.
  // nb: expected BUSY cycles. noise: re-assert START with other operands
  // while busy. chain: re-request in the DONE cycle with (ca, cb).
  task automatic run_op(input string tag, input int nb,
                        input logic [7:0] eq, input logic [7:0] er, input logic eerr,
                        input logic noise, input logic chain,
                        input logic [7:0] ca, input logic [7:0] cb);
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    for (int k = 1; k <= nb; k++) begin
      if (k > 1) @(negedge i_clk);
      check({tag, " busy"}, {7'd0, o_busy}, 8'd1);
      check({tag, " done-while-busy"}, {7'd0, o_done}, 8'd0);
      check({tag, " q-hold"}, o_q, last_q);
      check({tag, " r-hold"}, o_r, last_r);
`ifdef DIV_ZERO_ERR_EN
      check({tag, " err-while-busy"}, {7'd0, o_err}, 8'd0);
`endif
      if (noise) begin
        i_start = (k < nb) ? 1'b1 : 1'b0;
        i_a     = 8'd9;
        i_b     = 8'd2;
      end
    end
    @(negedge i_clk);
    check({tag, " done"}, {7'd0, o_done}, 8'd1);
    check({tag, " busy-at-done"}, {7'd0, o_busy}, 8'd0);
    check({tag, " q"}, o_q, eq);
    check({tag, " r"}, o_r, er);
`ifdef DIV_ZERO_ERR_EN
    check({tag, " err"}, {7'd0, o_err}, {7'd0, eerr});
`else
    if (eerr) $display("note: %s is a divide-by-zero case without fast path", tag);
`endif
    last_q = eq;
    last_r = er;
    if (chain) begin
      start_op(ca, cb);
    end else begin
      @(negedge i_clk);
      check({tag, " done-pulse-end"}, {7'd0, o_done}, 8'd0);
      check({tag, " idle-busy"}, {7'd0, o_busy}, 8'd0);
      check({tag, " q-after"}, o_q, eq);
      check({tag, " r-after"}, o_r, er);
    end
  endtask

  initial begin
    int nb_zero;
`ifdef DIV_ZERO_ERR_EN
    nb_zero = 1;
`else
    nb_zero = 8;
`endif
    i_n_rst = 1'b0;
    i_start = 1'b0;
    i_a     = 8'd0;
    i_b     = 8'd0;
    #12;
    check("rst busy", {7'd0, o_busy}, 8'd0);
    check("rst done", {7'd0, o_done}, 8'd0);
    check("rst q", o_q, 8'd0);
    check("rst r", o_r, 8'd0);
`ifdef DIV_ZERO_ERR_EN
    check("rst err", {7'd0, o_err}, 8'd0);
`endif
    @(negedge i_clk);
    i_n_rst = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    check("idle busy", {7'd0, o_busy}, 8'd0);
    check("idle done", {7'd0, o_done}, 8'd0);

    start_op(8'd200, 8'd7);
    run_op("200/7", 8, 8'd28, 8'd4, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

    start_op(8'd255, 8'd1);
    run_op("255/1", 8, 8'd255, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    start_op(8'd5, 8'd9);
    run_op("5/9", 8, 8'd0, 8'd5, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    start_op(8'd0, 8'd13);
    run_op("0/13", 8, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

    start_op(8'd77, 8'd0);
    run_op("77/0", nb_zero, 8'd255, 8'd77, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);

    start_op(8'd100, 8'd3);
    run_op("100/3 ignore", 8, 8'd33, 8'd1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);

    start_op(8'd200, 8'd7);
    run_op("b2b first", 8, 8'd28, 8'd4, 1'b0, 1'b0, 1'b1, 8'd9, 8'd2);
    run_op("b2b second", 8, 8'd4, 8'd1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

    // Reset in the 4th BUSY cycle abandons the operation.
    start_op(8'd50, 8'd5);
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    check("pre-rst busy", {7'd0, o_busy}, 8'd1);
    #2 i_n_rst = 1'b0;
    #1;
    check("mid-rst busy", {7'd0, o_busy}, 8'd0);
    check("mid-rst done", {7'd0, o_done}, 8'd0);
    check("mid-rst q", o_q, 8'd0);
    check("mid-rst r", o_r, 8'd0);
    @(negedge i_clk);
    i_n_rst = 1'b1;
    last_q = 8'd0;
    last_r = 8'd0;
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      check("post-rst no done", {7'd0, o_done}, 8'd0);
      check("post-rst no busy", {7'd0, o_busy}, 8'd0);
    end
    start_op(8'd60, 8'd7);
    run_op("60/7 after rst", 8, 8'd8, 8'd4, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
